// File: rtl/dma_register_bank.sv
// Host-visible DMA control registers (block size/count, transfer mode, command,
// present state, block gap control) plus the transfer state machine that drives them.
module dma_register_bank #(
  parameter int          ADDR_W       = 8,
  parameter int          BLK_CNT_W    = 16,
  parameter logic [11:0] BLK_SIZE_RST = 12'h200
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              Wr_En,
  input  logic              Rd_En,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [15:0]       Wr_Data,
  input  logic [1:0]        Byte_En,
  output logic [15:0]       Rd_Data,
  output logic              Rd_Valid,
  input  logic              Block_Done,
  output logic [15:0]       Block_Size,
  output logic [15:0]       Block_Count,
  output logic [15:0]       Transfer_Mode,
  output logic [15:0]       Command,
  output logic [31:0]       Present_State,
  output logic [7:0]        Block_Gap_Control,
  output logic              Cmd_Issue,
  output logic              Cmd_Rejected,
  output logic              Transfer_Complete,
  output logic              Block_Gap_Event,
  output logic [1:0]        dbg_state
);

  // Host port: a write is taken on every rising edge with Wr_En=1 (no stall);
  // Rd_En at edge N yields Rd_Valid=1 and Rd_Data from pre-edge register contents
  // after edge N. There is no ready/back-pressure on either strobe.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_GAP  = 2'd3
  } xfer_state_t;

  localparam logic [ADDR_W-1:0] OFF_BS  = ADDR_W'('h04);
  localparam logic [ADDR_W-1:0] OFF_BC  = ADDR_W'('h06);
  localparam logic [ADDR_W-1:0] OFF_TM  = ADDR_W'('h0C);
  localparam logic [ADDR_W-1:0] OFF_CMD = ADDR_W'('h0E);
  localparam logic [ADDR_W-1:0] OFF_PSL = ADDR_W'('h24);
  localparam logic [ADDR_W-1:0] OFF_PSH = ADDR_W'('h26);
  localparam logic [ADDR_W-1:0] OFF_BGC = ADDR_W'('h2A);

  xfer_state_t           state_q, state_d;
  logic                  gap_dir_q, gap_dir_d;
  logic [11:0]           blk_size_q;
  logic [BLK_CNT_W-1:0]  blk_cnt_q;
  logic [15:0]           tm_q;
  logic [15:0]           cmd_q;
  logic                  bgc_stop_q;
  logic                  bgc_cont_q;

  logic                  sel_bs, sel_bc, sel_tm, sel_cmd, sel_psl, sel_psh, sel_bgc;
  logic                  active;
  logic                  done_hit, cnt_dec, xfer_end, gap_hit;
  logic                  wr_cmd, cmd_ok, cmd_rej, cmd_start;
  logic                  bgc_new0, resume;
  logic [15:0]           cmd_new;
  logic [15:0]           cnt_merged;
  logic [15:0]           tm_merged;
  logic [11:0]           bs_new;
  logic [31:0]           ps_word;
  logic [15:0]           rd_word;

  // Addr[0] is masked out of the comparison so odd byte addresses alias the word.
  function automatic logic addr_hit(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] off);
    return ((a ^ off) & ~ADDR_W'(1)) == '0;
  endfunction

  function automatic logic [15:0] merge16(input logic [15:0] cur, input logic [15:0] wd,
                                          input logic [1:0] be);
    return {be[1] ? wd[15:8] : cur[15:8], be[0] ? wd[7:0] : cur[7:0]};
  endfunction

  assign sel_bs  = addr_hit(Addr, OFF_BS);
  assign sel_bc  = addr_hit(Addr, OFF_BC);
  assign sel_tm  = addr_hit(Addr, OFF_TM);
  assign sel_cmd = addr_hit(Addr, OFF_CMD);
  assign sel_psl = addr_hit(Addr, OFF_PSL);
  assign sel_psh = addr_hit(Addr, OFF_PSH);
  assign sel_bgc = addr_hit(Addr, OFF_BGC);

  assign active     = (state_q == ST_WR) || (state_q == ST_RD);
  assign cmd_new    = merge16(cmd_q, Wr_Data, Byte_En);
  assign cnt_merged = merge16(16'(blk_cnt_q), Wr_Data, Byte_En);
  assign tm_merged  = merge16(tm_q, Wr_Data, Byte_En) & 16'h0033;
  assign bs_new     = {Byte_En[1] ? Wr_Data[11:8] : blk_size_q[11:8],
                       Byte_En[0] ? Wr_Data[7:0]  : blk_size_q[7:0]};

  // Block_Done is resolved first; the Command decision uses the pre-cycle Active.
  assign done_hit  = Block_Done && active;
  assign cnt_dec   = done_hit && tm_q[1] && (blk_cnt_q != '0);
  assign xfer_end  = done_hit && (!tm_q[5] || (tm_q[1] && (blk_cnt_q == BLK_CNT_W'(1))));
  assign gap_hit   = done_hit && !xfer_end && bgc_stop_q;
  assign wr_cmd    = Wr_En && sel_cmd;
  assign cmd_ok    = wr_cmd && !active;
  assign cmd_rej   = wr_cmd && active;
  assign cmd_start = cmd_ok && cmd_new[5];

  // Continue-request is honoured only from a gap stop with stop-at-gap cleared by the same write.
  assign bgc_new0 = Byte_En[0] ? Wr_Data[0] : bgc_stop_q;
  assign resume   = Wr_En && sel_bgc && Byte_En[0] && Wr_Data[1] &&
                    (state_q == ST_GAP) && !bgc_new0;

  always_comb begin
    state_d   = state_q;
    gap_dir_d = gap_dir_q;
    case (state_q)
      ST_WR, ST_RD: begin
        if (xfer_end) begin
          state_d = ST_IDLE;
        end else if (gap_hit) begin
          state_d   = ST_GAP;
          gap_dir_d = (state_q == ST_RD);
        end
      end
      ST_IDLE: begin
        if (cmd_start) state_d = tm_q[4] ? ST_RD : ST_WR;
      end
      ST_GAP: begin
        if (cmd_start) begin
          state_d = tm_q[4] ? ST_RD : ST_WR;
        end else if (resume) begin
          state_d = gap_dir_q ? ST_RD : ST_WR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      gap_dir_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_dir_q <= gap_dir_d;
    end
  end

  assign ps_word = {22'b0, (state_q == ST_RD), (state_q == ST_WR), 8'b0};

  always_comb begin
    rd_word = '0;
    if (sel_bs)       rd_word = {4'b0, blk_size_q};
    else if (sel_bc)  rd_word = 16'(blk_cnt_q);
    else if (sel_tm)  rd_word = tm_q;
    else if (sel_cmd) rd_word = cmd_q;
    else if (sel_psl) rd_word = ps_word[15:0];
    else if (sel_psh) rd_word = ps_word[31:16];
    else if (sel_bgc) rd_word = {14'b0, bgc_cont_q, bgc_stop_q};
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      blk_size_q        <= BLK_SIZE_RST;
      blk_cnt_q         <= '0;
      tm_q              <= '0;
      cmd_q             <= '0;
      bgc_stop_q        <= 1'b0;
      bgc_cont_q        <= 1'b0;
      Rd_Data           <= '0;
      Rd_Valid          <= 1'b0;
      Cmd_Issue         <= 1'b0;
      Cmd_Rejected      <= 1'b0;
      Transfer_Complete <= 1'b0;
      Block_Gap_Event   <= 1'b0;
    end else begin
      Rd_Valid <= Rd_En;
      if (Rd_En) Rd_Data <= rd_word;

      if (Wr_En && sel_bs && !active) blk_size_q <= bs_new;
      if (Wr_En && sel_bc && !active) begin
        blk_cnt_q <= cnt_merged[BLK_CNT_W-1:0];
      end else if (cnt_dec) begin
        blk_cnt_q <= blk_cnt_q - BLK_CNT_W'(1);
      end
      if (Wr_En && sel_tm && !active) tm_q <= tm_merged;
      if (cmd_ok) cmd_q <= cmd_new;
      if (Wr_En && sel_bgc) bgc_stop_q <= bgc_new0;
      bgc_cont_q <= resume;

      Cmd_Issue         <= cmd_ok;
      Cmd_Rejected      <= cmd_rej;
      Transfer_Complete <= xfer_end;
      Block_Gap_Event   <= gap_hit;
    end
  end

  assign Block_Size        = {4'b0, blk_size_q};
  assign Block_Count       = 16'(blk_cnt_q);
  assign Transfer_Mode     = tm_q;
  assign Command           = cmd_q;
  assign Present_State     = ps_word;
  assign Block_Gap_Control = {6'b0, bgc_cont_q, bgc_stop_q};
  assign dbg_state         = state_q;

endmodule
